// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with framing-error and line-break recovery.
// Optional even-parity (8E1) frame support is enabled with the UART_RX_PARITY_EN macro.
module uart_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             sync1_q, sync2_q;
  logic             rxd_s;

  assign rxd_s = sync2_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is already high again at mid-bit is treated as noise.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rxd_s != ^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_both = 0;
  int busy_drop = 0;
  int last_fall = 0;
  logic [7:0] vdata[$];
  int         vtime[$];

  uart_receiver #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        n_valid++;
        vdata.push_back(data);
        vtime.push_back(cyc);
      end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (valid && frame_err) n_both++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 8 && busy !== 1'b1) busy_drop++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit with_par, input logic par, input logic stop);
    last_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (with_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    repeat (4) tick();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %0b expected 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single();
    int v0, f0, lat;
    v0 = n_valid; f0 = n_ferr; busy_drop = 0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", data); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", n_ferr - f0); end
    checks++; if (busy_drop !== 0) begin errors++; $display("FAIL single_busy_high: got %0d drops expected 0", busy_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b expected 0", busy); end
    lat = (vtime.size() > 0) ? vtime[$] - last_fall : -1;
    checks++; if (lat < 153 || lat > 156) begin errors++; $display("FAIL single_latency: got %0d expected 153..156", lat); end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
    v0 = n_valid;
    for (int k = 0; k < 3; k++) send_frame(exp_d[k], 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_valid - v0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n_valid - v0); end
    if (n_valid - v0 == 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (vdata[v0 + k] !== exp_d[k]) begin errors++; $display("FAIL b2b_data%0d: got %0h expected %0h", k, vdata[v0 + k], exp_d[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (vtime[v0 + k] - vtime[v0 + k - 1] !== 160) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d expected 160", k, vtime[v0 + k] - vtime[v0 + k - 1]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int v0, f0, k;
    bit saw_busy;
    v0 = n_valid; f0 = n_ferr; saw_busy = 0; k = 0;
    rxd = 1'b0;
    repeat (4) begin tick(); k++; if (busy) saw_busy = 1; end
    rxd = 1'b1;
    while (k < 40 && !(saw_busy && busy === 1'b0)) begin
      tick(); k++;
      if (busy) saw_busy = 1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rose: got %0b expected 1", saw_busy); end
    checks++; if (k < 9 || k > 13) begin errors++; $display("FAIL glitch_busy_fall: got %0d cycles expected 9..13", k); end
    checks++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d expected 0", (n_valid - v0) + (n_ferr - f0)); end
  endtask

  task automatic test_break();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (300) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_hold: got %0b expected 1", busy); end
    rxd = 1'b1;
    repeat (10) tick();
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL break_valid_count: got %0d expected 0", n_valid - v0); end
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL break_data_kept: got %0h expected 3c", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_release: got %0b expected 0", busy); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL break_recover_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL break_recover_data: got %0h expected 81", data); end
  endtask

  task automatic test_reset_midframe();
    int v0, f0;
    logic [7:0] b;
    b = 8'hC3;
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rxd = b[4];
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    rxd = 1'b1;
    repeat (40) tick();
    checks++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL abort_strobe: got %0d expected 0", (n_valid - v0) + (n_ferr - f0)); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data: got %0h expected 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data !== 8'h12) begin errors++; $display("FAIL abort_next_data: got %0h expected 12", data); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %0h expected 07", data); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL par_good_perr: got %0d expected 0", n_perr - p0); end
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_bad_perr: got %0d expected 1", n_perr - p0); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL par_bad_valid: got %0d expected 1", n_valid - v0); end
    checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %0h expected 07", data); end
`else
    checks++; if (n_perr !== 0) begin errors++; $display("FAIL parity_tied: got %0d pulses expected 0", n_perr); end
`endif
  endtask

  task automatic test_exclusive();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_ferr_overlap: got %0d expected 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_parity();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
